// File: rtl/pcm_pkg.sv
// -----------------------------------------------------------------------------
// pcm_pkg
// Shared types and defaults for the PCM frame buffer.
//   pcm_sample_t : one signed PCM sample at the default width
//   pcm_frame_t  : packed array of one sample per channel; slot c sits at
//                  bits [c*PCM_DATA_W +: PCM_DATA_W]
//   chan_idx_w() : width of a channel index (at least 1 bit)
// -----------------------------------------------------------------------------
package pcm_pkg;

  localparam int PCM_DATA_W   = 16;
  localparam int PCM_CHANNELS = 2;
  localparam int PCM_DEPTH    = 16;

  typedef logic signed [PCM_DATA_W-1:0] pcm_sample_t;
  typedef pcm_sample_t [PCM_CHANNELS-1:0] pcm_frame_t;

  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pcm_frame_assembler.sv
// -----------------------------------------------------------------------------
// pcm_frame_assembler
// Gathers one sample per channel into a frame. Each channel strobes on its own.
// The frame commits in the cycle where every channel is either already captured
// or strobing now. frame_data includes the samples arriving in that cycle.
// A channel that strobes twice before its frame commits keeps the newer sample
// and raises misalign_evt for that cycle.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   in_data       : CHANNELS*DATA_W per-channel samples
//   in_valid      : per-channel one-cycle strobes
//   frame_data    : assembled frame (valid when commit is high)
//   commit        : frame complete this cycle
//   misalign_evt  : a captured channel was strobed again this cycle
// -----------------------------------------------------------------------------
module pcm_frame_assembler
  import pcm_pkg::*;
#(
  parameter int DATA_W   = PCM_DATA_W,
  parameter int CHANNELS = PCM_CHANNELS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS*DATA_W-1:0]   frame_data,
  output logic                         commit,
  output logic                         misalign_evt
);

  logic [CHANNELS-1:0]        captured_q, captured_d;
  logic [CHANNELS*DATA_W-1:0] slots_q, slots_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    slots_d = slots_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_valid[c]) begin
        slots_d[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
      end
    end
    commit       = &(captured_q | in_valid);
    misalign_evt = |(captured_q & in_valid);
    captured_d   = commit ? '0 : (captured_q | in_valid);
  end

  assign frame_data = slots_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      captured_q <= '0;
    end else begin
      captured_q <= captured_d;
    end
  end

  // NOTE: sample storage carries no reset; the captured mask alone decides
  // whether a slot's content means anything, so data flops stay reset-free.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

endmodule

// File: rtl/pcm_frame_fifo.sv
// -----------------------------------------------------------------------------
// pcm_frame_fifo
// Multi-channel PCM frame buffer: assembles per-channel samples into frames,
// stores up to DEPTH frames in a circular buffer and serialises them one word
// per transfer on a ready/valid port.
// Optional feature macro: PCM_FIFO_DROP_CNT_EN adds the saturating 8-bit
// drop_cnt output; without it neither the port nor the counter exists.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_data, in_valid   : per-channel samples and strobes
//   out_data, out_chan  : current word and its channel index
//   out_last            : final channel word of the frame
//   out_valid, out_ready: word handshake
//   level               : stored frame count
//   wm_req              : registered level >= WATERMARK
//   overflow, misalign  : sticky error flags
//   clr_status          : clears sticky flags (and drop_cnt); set wins
//   drop_cnt            : dropped-frame count (PCM_FIFO_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module pcm_frame_fifo
  import pcm_pkg::*;
#(
  parameter int DATA_W    = PCM_DATA_W,
  parameter int CHANNELS  = PCM_CHANNELS,
  parameter int DEPTH     = PCM_DEPTH,
  parameter int WATERMARK = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [CHANNELS*DATA_W-1:0]           in_data,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [DATA_W-1:0]                    out_data,
  output logic [chan_idx_w(CHANNELS)-1:0]      out_chan,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(DEPTH+1)-1:0]           level,
  output logic                                 wm_req,
  output logic                                 overflow,
  output logic                                 misalign,
  input  logic                                 clr_status
`ifdef PCM_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                           drop_cnt
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int CHAN_W = chan_idx_w(CHANNELS);

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_WM   = LVL_W'(WATERMARK);
  localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(CHANNELS-1);

  logic [CHANNELS*DATA_W-1:0] frame_data;
  logic                       commit;
  logic                       misalign_evt;

  pcm_frame_assembler #(
    .DATA_W   (DATA_W),
    .CHANNELS (CHANNELS)
  ) u_assembler (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .frame_data   (frame_data),
    .commit       (commit),
    .misalign_evt (misalign_evt)
  );

  logic [CHANNELS*DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CHAN_W-1:0] word_idx_q, word_idx_d;
  logic              wm_req_q, wm_req_d;
  logic              overflow_q, overflow_d;
  logic              misalign_q, misalign_d;

  logic not_empty, is_last, xfer, pop, full, wr_en, drop;
  logic [CHANNELS*DATA_W-1:0] rd_frame;

  always_comb begin
    not_empty = (level_q != '0);
    is_last   = (word_idx_q == LAST_IDX);
    xfer      = not_empty && out_ready;
    pop       = xfer && is_last;
    full      = (level_q == LVL_FULL);
    // A pop in the same cycle frees the slot the commit would need.
    wr_en     = commit && (!full || pop);
    drop      = commit && full && !pop;

    word_idx_d = word_idx_q;
    if (xfer) begin
      word_idx_d = is_last ? '0 : word_idx_q + CHAN_W'(1);
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);

    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Registered from the current level so the MCU line never glitches.
    wm_req_d   = (level_q >= LVL_WM);
    overflow_d = drop | (overflow_q & ~clr_status);
    misalign_d = misalign_evt | (misalign_q & ~clr_status);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      word_idx_q <= '0;
      wm_req_q   <= 1'b0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      word_idx_q <= word_idx_d;
      wm_req_q   <= wm_req_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= frame_data;
    end
  end

  // Output word is forced to zero while empty so uninitialised memory never
  // reaches the port.
  assign rd_frame = mem[rd_ptr_q];

  always_comb begin
    out_data = '0;
    if (not_empty) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (word_idx_q == CHAN_W'(c)) begin
          out_data = rd_frame[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign out_chan  = word_idx_q;
  assign out_last  = is_last;
  assign out_valid = not_empty;
  assign level     = level_q;
  assign wm_req    = wm_req_q;
  assign overflow  = overflow_q;
  assign misalign  = misalign_q;

`ifdef PCM_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = clr_status ? 8'd0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 8'hFF)) begin
      drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_pcm_frame_fifo
// Self-checking bench for pcm_frame_fifo at the default configuration
// (16-bit samples, 2 channels, 16 frames, watermark 8). A queue-of-frames
// reference model tracks the expected port state every cycle; directed steps
// cover the named scenarios and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pcm_frame_fifo;
  import pcm_pkg::*;

  localparam int DW = PCM_DATA_W;
  localparam int CH = PCM_CHANNELS;
  localparam int DP = PCM_DEPTH;
  localparam int WM = 8;
  localparam int CW = chan_idx_w(CH);
  localparam int LW = $clog2(DP+1);

  logic              clk;
  logic              reset_n;
  logic [CH*DW-1:0]  in_data;
  logic [CH-1:0]     in_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              wm_req;
  logic              overflow;
  logic              misalign;
  logic              clr_status;
`ifdef PCM_FIFO_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  pcm_frame_fifo #(
    .DATA_W    (DW),
    .CHANNELS  (CH),
    .DEPTH     (DP),
    .WATERMARK (WM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .wm_req     (wm_req),
    .overflow   (overflow),
    .misalign   (misalign),
    .clr_status (clr_status)
`ifdef PCM_FIFO_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  pcm_frame_t q[$];
  pcm_frame_t m_slots;
  logic [CH-1:0] m_cap;
  int  m_widx;
  bit  m_wm, m_ovf, m_mis;
  int  m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cap  = '0;
    m_widx = 0;
    m_wm   = 1'b0;
    m_ovf  = 1'b0;
    m_mis  = 1'b0;
    m_drop = 0;
  endtask

  task automatic compare_outputs();
    logic [DW-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0][m_widx] : '0;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("level",     32'(level),     32'(q.size()));
    check("out_data",  32'(out_data),  32'(exp_data));
    check("out_chan",  32'(out_chan),  32'(m_widx));
    check("out_last",  32'(out_last),  32'(m_widx == CH-1));
    check("wm_req",    32'(wm_req),    32'(m_wm));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("misalign",  32'(misalign),  32'(m_mis));
`ifdef PCM_FIFO_DROP_CNT_EN
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
`endif
  endtask

  task automatic model_step();
    int n;
    bit xfer, last, pop, all_in, drop;
    pcm_frame_t nf;
    n      = q.size();
    xfer   = (n != 0) && out_ready;
    last   = (m_widx == CH-1);
    pop    = xfer && last;
    all_in = &(m_cap | in_valid);
    drop   = all_in && (n == DP) && !pop;
    nf     = m_slots;
    for (int c = 0; c < CH; c++) begin
      if (in_valid[c]) nf[c] = in_data[c*DW +: DW];
    end
    m_wm    = (n >= WM);
    m_mis   = (|(m_cap & in_valid)) || (m_mis && !clr_status);
    m_ovf   = drop || (m_ovf && !clr_status);
    if (clr_status) m_drop = 0;
    if (drop && m_drop < 255) m_drop++;
    m_slots = nf;
    if (xfer) m_widx = last ? 0 : m_widx + 1;
    if (pop) void'(q.pop_front());
    if (all_in && !drop) q.push_back(nf);
    m_cap = all_in ? '0 : (m_cap | in_valid);
  endtask

  // One clock: check pre-edge state, advance model, take the edge, release
  // the one-cycle strobes.
  task automatic cycle();
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
    in_valid   = '0;
    clr_status = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input int c, input logic [DW-1:0] v);
    in_valid    = '0;
    in_valid[c] = 1'b1;
    in_data[c*DW +: DW] = v;
    cycle();
  endtask

  task automatic commit_frame(input pcm_frame_t f);
    in_valid = '1;
    in_data  = f;
    cycle();
  endtask

  function automatic pcm_frame_t rand_frame();
    pcm_frame_t f;
    for (int c = 0; c < CH; c++) f[c] = DW'($urandom);
    return f;
  endfunction

  task automatic do_reset(input string tag);
    in_valid   = '0;
    clr_status = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_valid"},    32'(out_valid), 32'd0);
    check({tag, "_data"},     32'(out_data),  32'd0);
    check({tag, "_chan"},     32'(out_chan),  32'd0);
    check({tag, "_last"},     32'(out_last),  32'(CH == 1));
    check({tag, "_level"},    32'(level),     32'd0);
    check({tag, "_wm"},       32'(wm_req),    32'd0);
    check({tag, "_overflow"}, 32'(overflow),  32'd0);
    check({tag, "_misalign"}, 32'(misalign),  32'd0);
`ifdef PCM_FIFO_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 32'(drop_cnt),  32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b0;
    clr_status = 1'b0;
    m_slots    = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Basic stereo frame
    strobe(0, 16'h1234);
    idle(1);
    strobe(1, 16'hABCD);
    check("t1_level", 32'(level), 32'd1);
    check("t1_w0",    32'(out_data), 32'h1234);
    check("t1_c0",    32'(out_chan), 32'd0);
    out_ready = 1'b1;
    cycle();
    check("t1_w1",    32'(out_data), 32'hABCD);
    check("t1_c1",    32'(out_chan), 32'd1);
    check("t1_last",  32'(out_last), 32'd1);
    cycle();
    check("t1_empty", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Fill to watermark
    for (int i = 0; i < WM; i++) commit_frame(rand_frame());
    check("t2_level8",  32'(level),  32'(WM));
    check("t2_wm_lag",  32'(wm_req), 32'd0);
    idle(1);
    check("t2_wm_rise", 32'(wm_req), 32'd1);
    out_ready = 1'b1;
    idle(CH);
    out_ready = 1'b0;
    check("t2_level7",  32'(level),  32'(WM-1));
    check("t2_wm_hold", 32'(wm_req), 32'd1);
    idle(1);
    check("t2_wm_fall", 32'(wm_req), 32'd0);

    // Overflow: 17 frames into 16
    do_reset("rst1");
    for (int i = 0; i < DP+1; i++) commit_frame(rand_frame());
    check("t3_level",    32'(level),    32'(DP));
    check("t3_overflow", 32'(overflow), 32'd1);
`ifdef PCM_FIFO_DROP_CNT_EN
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    clr_status = 1'b1;
    cycle();
    check("t3_clr", 32'(overflow), 32'd0);

    // Full with a pop coinciding with a commit
    out_ready = 1'b1;
    idle(CH-1);
    commit_frame(rand_frame());
    check("t4_level",    32'(level),    32'(DP));
    check("t4_overflow", 32'(overflow), 32'd0);
    idle(DP*CH);
    check("t4_drained",  32'(level),    32'd0);
    out_ready = 1'b0;

    // Misalign
    strobe(0, 16'h0001);
    strobe(0, 16'h0002);
    strobe(1, 16'h0003);
    check("t5_misalign", 32'(misalign), 32'd1);
    check("t5_w0",       32'(out_data), 32'h0002);
    out_ready = 1'b1;
    cycle();
    check("t5_w1",       32'(out_data), 32'h0003);
    cycle();
    out_ready = 1'b0;
    clr_status = 1'b1;
    cycle();
    check("t5_clr",      32'(misalign), 32'd0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) commit_frame(rand_frame());
    strobe(0, 16'h5555);
    do_reset("rst2");
    strobe(1, 16'h6666);
    check("t6_no_commit", 32'(level),     32'd0);
    check("t6_no_valid",  32'(out_valid), 32'd0);
    idle(2);

    // Randomized traffic: a fill-heavy phase then a drain-heavy phase
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c] = ($urandom_range(0, 99) < 45);
        in_data[c*DW +: DW] = DW'($urandom);
      end
      out_ready  = (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_status = ($urandom_range(0, 49) == 0);
      cycle();
    end
    out_ready = 1'b1;
    idle(DP*CH + 4);
    check("final_empty", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_frame_fifo.md
# pcm_frame_fifo

Parametrised multi-channel PCM frame buffer between the decimation filter chain and the MCU SPI interface. Collects one sample per channel into a frame, stores frames in a circular buffer, and serialises them word-by-word over a ready/valid port. Provides a registered watermark request, a fill level and sticky error flags. Replaces the fixed single-channel, pulse-stretched `audio_valid` handoff.

## Interface
- `DATA_W`, 16: PCM sample width, signed two's complement.
- `CHANNELS`, 2: channels per frame, 1..8.
- `DEPTH`, 16: frame capacity, power of two, at least 2.
- `WATERMARK`, 8: level at which `wm_req` asserts, 1..DEPTH.
- `clk` input 1: system clock. Same domain as the filter chain.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_data` input CHANNELS*DATA_W: per-channel samples. Channel c occupies `[c*DATA_W +: DATA_W]`.
- `in_valid` input CHANNELS: one-cycle per-channel sample strobes. Channels are independent.
- `out_data` output DATA_W: current output word.
- `out_chan` output max(1,$clog2(CHANNELS)): channel index of `out_data`.
- `out_last` output 1: high on the final channel word of a frame.
- `out_valid` output 1: a word is available.
- `out_ready` input 1: consumer accepts the word.
- `level` output $clog2(DEPTH+1): number of stored frames.
- `wm_req` output 1: registered `level >= WATERMARK`.
- `overflow` output 1: sticky flag, a frame was dropped.
- `misalign` output 1: sticky flag, a channel was re-strobed before its frame completed.
- `clr_status` input 1: one-cycle pulse that clears `overflow`, `misalign` and `drop_cnt`.
- `drop_cnt` output 8: only when `PCM_FIFO_DROP_CNT_EN` is defined.

## Operation
- Assembler:
  - Holds a `captured[CHANNELS]` mask and a frame register.
  - When `in_valid[c]` is high, the frame register's slot c loads `in_data[c]` and `captured[c]` sets.
  - If `captured[c]` is already set, the new sample replaces the old one and `misalign` sets.
- Commit:
  - A commit occurs in the cycle where (`captured` | `in_valid`) is all ones.
  - The frame, including samples arriving that cycle, is written at `wr_ptr`. `captured` clears.
  - A commit while `level == DEPTH`, with no pop in the same cycle, drops the frame. Stored data is untouched, `overflow` sets, and `drop_cnt` increments.
  - A commit while full with a pop in the same cycle is accepted. `level` is unchanged.
- Read side:
  - `out_valid = (level != 0)`.
  - `out_data` is slot `word_idx` of the frame at `rd_ptr`. `out_chan = word_idx`. `out_last = (word_idx == CHANNELS-1)`.
  - A transfer happens when `out_valid && out_ready`. `word_idx` increments on each transfer.
  - On a transfer with `out_last` high, `word_idx` returns to 0, `rd_ptr` advances and `level` decrements (a pop).
  - `out_data`, `out_chan` and `out_last` hold steady while `out_valid && !out_ready`.
- Pointers:
  - `rd_ptr` and `wr_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is the authority for full and empty.
  - Commit and pop in the same cycle leave `level` unchanged.
- Status flags:
  - `clr_status` clears the sticky flags.
  - If a set event coincides with `clr_status`, the set wins.
- Reset clears all pointers, `level`, `word_idx`, `captured`, the flags, `wm_req` and `drop_cnt`.
- Frame memory contents are not reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `out_last`=0 (CHANNELS=1: 1), `level`=0, `wm_req`=0, `overflow`=0, `misalign`=0, `drop_cnt`=0.
- Commit latency: final channel strobe at edge N causes the write at N. `level` and `out_valid` update after N.
- Throughput on an empty FIFO: first word is valid one cycle after the completing strobe.
- `wm_req` lags `level` by one cycle and is glitch-free. It is intended as the MCU data-ready line.
- With `out_ready` held high, a frame drains in CHANNELS cycles.
- Sustained drain rate is one word per cycle.

## Configuration
- `PCM_FIFO_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` output.
  - `drop_cnt` is an 8-bit count of dropped frames that saturates at 255.
  - `clr_status` clears it.
- Not defined: no port and no counter logic. `overflow` behaves identically either way.

## Structure
- Package `pcm_pkg` holds:
  - the `pcm_sample_t` typedef (signed DATA_W);
  - the default DATA_W, CHANNELS and DEPTH constants;
  - a `pcm_frame_t` packed-array typedef.
- Sub-module `pcm_frame_assembler` contains the `captured` mask, the slot registers, the misalign detection and the commit strobe.
- The top module owns the memory, pointers, read serialiser and status.

## Test plan
- Basic stereo frame, CHANNELS=2:
  - Stimulus: strobe ch0=0x1234, then ch1=0xABCD two cycles later.
  - Required: `level`=1. With `out_ready` high, words 0x1234 (chan 0), then 0xABCD (chan 1, `out_last`). Then `level`=0.
- Fill to watermark with `out_ready` low: commit 8 frames.
  - Required: `wm_req` rises one cycle after `level` reaches 8 and falls one cycle after `level` drops to 7.
- Overflow:
  - Stimulus: commit 17 frames with DEPTH=16 and no reads.
  - Required: `level`=16, `overflow`=1, `drop_cnt`=1. Frames 0..15 read back intact in order.
- Full with simultaneous pop:
  - Stimulus: full FIFO; the final `out_last` transfer coincides with a commit.
  - Required: frame accepted, `level` stays 16, `overflow` stays 0.
- Misalign:
  - Stimulus: strobe ch0=0x0001, ch0=0x0002, then ch1=0x0003.
  - Required: `misalign`=1; the frame reads 0x0002, 0x0003. Then `clr_status` clears the flag.
- Reset mid-frame:
  - Stimulus: assert `reset_n` low after a ch0 strobe with 3 frames stored.
  - Required: all outputs at reset values. A following ch1 strobe alone does not commit.
